// File: rtl/exc_dispatcher.sv
// ============================================================================
// Module   : exc_dispatcher
// Brief    : Serialises execute-stage exceptions onto CP0 and turns the CP0 epc
//            answer into stall / flush / PC redirect for fetch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_dispatcher #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_sysReq,
  input  logic              i_bpReq,
  input  logic              i_trReq,
  input  logic [DATA_W-1:0] i_instrPc,
  input  logic              i_cop0Busy,
  output logic [4:0]        o_excCode,
  output logic [DATA_W-1:0] o_excPc,
  input  logic              i_epcValid,
  input  logic [DATA_W-1:0] i_epcValue,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_redirValid,
  output logic [DATA_W-1:0] o_redirPc,
  output logic              o_droppedPulse,
  output logic [CNT_W-1:0]  o_takenCnt,
  output logic [CNT_W-1:0]  o_droppedCnt
);

  localparam logic [4:0] c_EXC_SYS  = 5'd8;
  localparam logic [4:0] c_EXC_BP   = 5'd9;
  localparam logic [4:0] c_EXC_TR   = 5'd13;
  localparam logic [4:0] c_EXC_NONE = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_stateNxt;
  logic [4:0]        r_code;
  logic [4:0]        w_codeNxt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] w_pcNxt;
  logic [CNT_W-1:0]  r_takenCnt;
  logic [CNT_W-1:0]  r_droppedCnt;
  logic              w_takenInc;
  logic              w_droppedInc;
  logic              w_anyReq;
  logic [4:0]        w_reqCode;

  assign w_anyReq = i_sysReq | i_bpReq | i_trReq;

  always_comb begin
    w_reqCode = c_EXC_TR;
    if (i_sysReq)     w_reqCode = c_EXC_SYS;
    else if (i_bpReq) w_reqCode = c_EXC_BP;
  end

  always_comb begin
    w_stateNxt     = r_state;
    w_codeNxt      = r_code;
    w_pcNxt        = r_pc;
    w_takenInc     = 1'b0;
    w_droppedInc   = 1'b0;
    o_excCode      = c_EXC_NONE;
    o_excPc        = '0;
    o_stall        = 1'b0;
    o_flush        = 1'b0;
    o_redirValid   = 1'b0;
    o_redirPc      = '0;
    o_droppedPulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall = w_anyReq;
        if (i_enable) begin
          // An ERET redirect squashes the (younger) requester, so it is not latched.
          if (i_epcValid) begin
            o_flush      = 1'b1;
            o_redirValid = 1'b1;
            o_redirPc    = i_epcValue;
          end else if (w_anyReq) begin
            w_codeNxt  = w_reqCode;
            w_pcNxt    = i_instrPc;
            w_stateNxt = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        o_stall   = 1'b1;
        o_excCode = r_code;
        o_excPc   = r_pc;
        if (i_enable && !i_cop0Busy) w_stateNxt = S_WAIT;
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_enable) begin
          w_stateNxt = S_IDLE;
          if (i_epcValid) begin
            o_flush      = 1'b1;
            o_redirValid = 1'b1;
            o_redirPc    = i_epcValue;
            w_takenInc   = 1'b1;
          end else begin
            o_droppedPulse = 1'b1;
            w_droppedInc   = 1'b1;
          end
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_code       <= c_EXC_NONE;
      r_pc         <= '0;
      r_takenCnt   <= '0;
      r_droppedCnt <= '0;
    end else if (i_enable) begin
      r_state <= w_stateNxt;
      r_code  <= w_codeNxt;
      r_pc    <= w_pcNxt;
      // Counters saturate rather than wrap.
      if (w_takenInc && (r_takenCnt != {CNT_W{1'b1}}))
        r_takenCnt <= r_takenCnt + CNT_W'(1);
      if (w_droppedInc && (r_droppedCnt != {CNT_W{1'b1}}))
        r_droppedCnt <= r_droppedCnt + CNT_W'(1);
    end
  end

  assign o_takenCnt   = r_takenCnt;
  assign o_droppedCnt = r_droppedCnt;

endmodule

`default_nettype wire
